// File: rtl/ysyx_23060062_mem_responder.sv
// ---------------------------------------------------------------------------
// ysyx_23060062_mem_responder
//
// Memory-side responder for the core's fetch/load/store bus. It accepts one
// request at a time, waits a fixed access latency, then returns the read word
// or a write acknowledge. A word-organised internal RAM backs all accesses.
//
// Optional feature macro: YSYX_23060062_MEM_FAULT_EN
//   defined   : accesses outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS) or with
//               addr[1:0] != 0 respond with resp_err_o=1. A faulting write
//               leaves the RAM untouched and a faulting read returns 0.
//   undefined : resp_err_o is always 0. The word index wraps modulo
//               DEPTH_WORDS and addr[1:0] is ignored.
//
// Parameters
//   ADDR_BASE    byte address mapped to RAM word 0
//   DEPTH_WORDS  RAM depth in 32-bit words (power of 2)
//   LATENCY      cycles from the request accept edge to resp_valid_o high (>=1)
//
// Ports
//   clk_i         clock; all state updates on posedge
//   rst_i         synchronous reset, active-high
//   req_valid_i   request present
//   req_ready_o   responder can accept a request (high only in IDLE)
//   req_write_i   1 = store, 0 = load/fetch
//   req_addr_i    byte address
//   req_wdata_i   store data
//   req_wmask_i   byte-lane enables, bit i -> wdata[8i+7:8i]
//   resp_valid_o  response present (high only in RESP)
//   resp_ready_i  initiator accepts the response
//   resp_rdata_o  load data; 0 for write responses
//   resp_err_o    access fault
//   dbg_state_o   current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Handshake rules: a transfer on either channel happens on a rising edge
// where valid and ready are both high. Once resp_valid_o is raised, it stays
// high and resp_rdata_o/resp_err_o stay stable until that transfer happens.
// req_valid_i is ignored (and may be X) whenever req_ready_o is low.
// ---------------------------------------------------------------------------
module ysyx_23060062_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wmask_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Counter only ever holds values up to LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) + 1 : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  // Operand set used for the actual RAM access. Normally the latched request;
  // with LATENCY==1 the access happens on the accept edge itself, so the live
  // request inputs are used instead.
  logic               do_access;
  logic               acc_wr;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic [3:0]         acc_wmask;
  logic [31:0]        acc_off;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_fault;
  logic [31:0]        mem_rd_word;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Word index: byte offset from the base, divided by four, truncated to the
  // RAM index width (this truncation is what makes the index wrap).
  assign acc_off     = acc_addr - ADDR_BASE;
  assign acc_idx     = IDX_W'(acc_off >> 2);
  assign mem_rd_word = mem_q[acc_idx];

`ifdef YSYX_23060062_MEM_FAULT_EN
  // 33-bit compare so a window ending exactly at 2^32 still works.
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
  assign acc_fault = (acc_addr < ADDR_BASE)
                  || ({1'b0, acc_addr} >= ADDR_END)
                  || (acc_addr[1:0] != 2'b00);
`else
  assign acc_fault = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          wr_d    = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          wmask_d = req_wmask_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            acc_wr    = req_write_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
            acc_wmask = req_wmask_i;
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            state_d   = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The edge that takes the counter from 1 to 0 is the edge entering
        // RESP; the RAM access happens on that same edge.
        if (cnt_q == CNT_W'(1)) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_access) begin
      err_d   = acc_fault;
      rdata_d = (acc_wr || acc_fault) ? 32'h0 : mem_rd_word;
    end
  end

  // -------------------------------------------------------------------------
  // Control and response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // RAM: contents are never reset. A reset on the commit edge wins, so a
  // write caught by reset never reaches memory.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_access && acc_wr && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign dbg_state_o  = state_q;

endmodule
